load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage that sits directly upstream of the 32-byte data memory in the tiny CPU. It accepts load/store requests from the control/execute side over a valid/ready handshake. Stores are buffered in a small in-order store queue that drains to memory in idle port cycles; loads are served with store-to-load forwarding and a registered one-cycle response. It also flags out-of-range addresses instead of letting them alias.

## Interface
Parameters:
- ADDR_W, 8, request/memory address width
- DATA_W, 8, data width
- MEM_AW, 5, implemented memory address bits (32 bytes)
- SQ_DEPTH, 2, store queue entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  one-cycle pulse, load result valid
- resp_rdata  out  DATA_W  load result
- fault  out  1  one-cycle pulse, accepted request had out-of-range address
- sq_empty  out  1  store queue empty; used by halt/fence logic
- mem_read  out  1  to data memory read enable
- mem_write  out  1  to data memory write enable
- mem_addr  out  ADDR_W  to data memory address
- mem_wdata  out  DATA_W  to data memory write data
- mem_rdata  in  DATA_W  from data memory, combinational read

## Operation
- Range check: address is in range iff req_addr[ADDR_W-1:MEM_AW] == 0. An out-of-range store is accepted, not enqueued, and faults. An out-of-range load is accepted and faults; its response returns 0x00.
- req_ready = 1 for loads always; for stores = !sq_full. The value is computed from registered count only and never depends on same-cycle dequeue.
- Store accept: the entry {addr[MEM_AW-1:0], wdata} is written at the tail; count increments at that edge.
- Load accept, in-range: the queue is searched youngest→oldest for a matching addr[MEM_AW-1:0].
  - Hit: forwarded data is registered into resp_rdata; no memory access.
  - Miss: mem_read=1 and mem_addr=req_addr in the accept cycle; mem_rdata is registered into resp_rdata.
- Port arbitration: a load miss owns the memory port. Otherwise, if the queue is non-empty, the head drains: mem_write=1, mem_addr/mem_wdata = head entry, dequeue at that edge.
- Load and drain never share a cycle; mem_read and mem_write are never both high.
- When neither loads nor drains: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Simultaneous store accept and drain: tail write and head dequeue in the same edge, count unchanged.
- Pointers wrap modulo SQ_DEPTH. count ranges 0..SQ_DEPTH. sq_full = count==SQ_DEPTH. sq_empty = count==0.

## Timing
- Reset values: resp_valid=0, resp_rdata=0, fault=0, sq_empty=1, all mem_* = 0, pointers and count = 0, all queue entries invalidated.
- Reset mid-operation discards buffered stores; memory contents are unaffected.
- Load latency: resp_valid is high exactly 1 cycle after the accept cycle, for one cycle. There is no backpressure, so back-to-back loads give back-to-back responses.
- fault is asserted in the cycle after accept, aligned with resp_valid for loads.
- Store visibility: a store accepted in cycle N drains at the earliest in cycle N+1 and is in memory after that edge. Until then it is visible to loads only via forwarding.
- A continuous stream of load misses starves the drain. This is acceptable: software fences via sq_empty.

## Structure
- Shared package tiny_mem_pkg holds ADDR_W, DATA_W, MEM_AW, SQ_DEPTH defaults and the store-entry struct {addr, data}.
- Sub-module store_queue holds the circular buffer, pointers, count, and youngest-match forwarding search (hit, data). load_store_unit holds the handshake, range check, port arbitration and response registers.

## Test plan
- Reset, then store 0x5A to 0x03 → req_ready=1. mem_write=1 with addr 0x03, data 0x5A in the next cycle; sq_empty returns to 1.
- Store 0x11 to 0x07, then store 0x22 to 0x07, then load 0x07 in consecutive cycles → resp_rdata=0x22 (youngest forward), mem_read stays 0 for that load.
- Fill queue (2 stores) while issuing continuous load misses → req_ready=0 for a third store until a load-free cycle drains one entry.
- Load 0x25 → fault=1 and resp_valid=1 with resp_rdata=0x00 one cycle later. Store to 0x80 → fault=1, no mem_write ever.
- Preload memory[0x0A]=0xC3, load 0x0A with empty queue → mem_read=1, mem_addr=0x0A in accept cycle; resp_rdata=0xC3 next cycle.
- Two stores queued, assert rst for 1 cycle → sq_empty=1, no subsequent mem_write, all outputs at reset values.

Source files
------------

// File: rtl/tiny_mem_pkg.sv
// Shared sizing and the store-queue entry layout for the tiny CPU data-memory path.
package tiny_mem_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int MEM_AW   = 5;
  localparam int SQ_DEPTH = 2;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } sq_entry_t;

endpackage

// File: rtl/store_queue.sv
// In-order circular store buffer with per-entry valid bits and a youngest-first
// forwarding search over the live entries.
module store_queue
  import tiny_mem_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enq,
  input  sq_entry_t         i_enq_entry,
  input  logic              i_deq,
  input  logic [MEM_AW-1:0] i_lookup_addr,
  output sq_entry_t         o_head,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_hit_data,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  sq_entry_t        r_entry [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (i_deq) begin
        r_head          <= r_head + PW'(1);
        r_valid[r_head] <= 1'b0;
      end
      if (i_enq) begin
        r_tail          <= r_tail + PW'(1);
        r_valid[r_tail] <= 1'b1;
      end
      case ({i_enq, i_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the payload array has no reset; r_valid alone decides which entries
  // are live, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (i_enq) r_entry[r_tail] <= i_enq_entry;
  end

  // Walk oldest to youngest so the last match (the youngest store) wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path
    // that never matches would infer a latch.
    logic [PW-1:0] idx;
    idx        = '0;
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PW'(k);
      if (r_valid[idx] && (r_entry[idx].addr == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_entry[idx].data;
      end
    end
  end

  assign o_head  = r_entry[r_head];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: request handshake, range check, store buffering with
// forwarding, single-port arbitration and a registered one-cycle load response.
module load_store_unit #(
  parameter int ADDR_W   = tiny_mem_pkg::ADDR_W,
  parameter int DATA_W   = tiny_mem_pkg::DATA_W,
  parameter int MEM_AW   = tiny_mem_pkg::MEM_AW,
  parameter int SQ_DEPTH = tiny_mem_pkg::SQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              fault,
  output logic              sq_empty,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  tiny_mem_pkg::sq_entry_t w_head;
  tiny_mem_pkg::sq_entry_t w_enq_entry;
  logic                    w_in_range;
  logic                    w_hit;
  logic [DATA_W-1:0]       w_hit_data;
  logic                    w_sq_empty;
  logic                    w_sq_full;
  logic                    w_accept;
  logic                    w_load;
  logic                    w_store;
  logic                    w_load_miss;
  logic                    w_drain;
  logic                    w_enq;

  logic                    r_resp_valid;
  logic [DATA_W-1:0]       r_resp_rdata;
  logic                    r_fault;

  // Upper address bits must be zero; anything else would alias into the 32 bytes.
  assign w_in_range  = (req_addr[ADDR_W-1:MEM_AW] == '0);
  assign req_ready   = req_we ? !w_sq_full : 1'b1;
  assign w_accept    = req_valid && req_ready;
  assign w_load      = w_accept && !req_we;
  assign w_store     = w_accept && req_we;
  assign w_enq       = w_store && w_in_range;
  assign w_load_miss = w_load && w_in_range && !w_hit;
  assign w_drain     = !w_load_miss && !w_sq_empty;

  assign w_enq_entry.addr = req_addr[MEM_AW-1:0];
  assign w_enq_entry.data = req_wdata;

  store_queue #(
    .DEPTH(SQ_DEPTH)
  ) u_store_queue (
    .clk          (clk),
    .rst          (rst),
    .i_enq        (w_enq),
    .i_enq_entry  (w_enq_entry),
    .i_deq        (w_drain),
    .i_lookup_addr(req_addr[MEM_AW-1:0]),
    .o_head       (w_head),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data),
    .o_empty      (w_sq_empty),
    .o_full       (w_sq_full)
  );

  // A load miss owns the port; otherwise the queue head drains.
  always_comb begin
    mem_read  = w_load_miss;
    mem_write = w_drain;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_load_miss) begin
      mem_addr = req_addr;
    end else if (w_drain) begin
      mem_addr  = ADDR_W'(w_head.addr);
      mem_wdata = w_head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_resp_valid <= w_load;
      r_fault      <= w_accept && !w_in_range;
      if (w_load) begin
        r_resp_rdata <= !w_in_range ? '0 : (w_hit ? w_hit_data : mem_rdata);
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign fault      = r_fault;
  assign sq_empty   = w_sq_empty;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against an architectural
// memory model plus a list of not-yet-drained stores.
module tb_load_store_unit;
  import tiny_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       fault;
  logic       sq_empty;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .fault     (fault),
    .sq_empty  (sq_empty),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical data memory seen by the DUT, and the program-order view of it.
  logic [7:0] phys_mem [32];
  logic [7:0] arch_mem [32];

  assign mem_rdata = phys_mem[mem_addr[4:0]];
  always @(posedge clk) if (mem_write) phys_mem[mem_addr[4:0]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    bit         is_load;
    logic [7:0] rdata;
    bit         flt;
  } exp_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } st_t;

  exp_t exp_q [$];
  st_t  pend_q [$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_sq_empty",   32'(sq_empty),   32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_fault",      32'(fault),      32'd0);
    check("rst_mem_read",   32'(mem_read),   32'd0);
    check("rst_mem_write",  32'(mem_write),  32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
  endtask

  // One cycle of stimulus; port behaviour is checked here, responses in the monitor.
  task automatic step(input bit v, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
    bit in_r;
    bit hit;
    bit exp_ready;
    bit acc;
    bit miss;
    bit drain;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    in_r = (addr[7:5] == 3'b000);
    hit  = 1'b0;
    foreach (pend_q[i]) if (pend_q[i].addr == addr[4:0]) hit = 1'b1;
    exp_ready = we ? (pend_q.size() < SQ_DEPTH) : 1'b1;
    acc   = v && exp_ready;
    miss  = acc && !we && in_r && !hit;
    drain = !miss && (pend_q.size() > 0);

    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("sq_empty",  32'(sq_empty),  32'(pend_q.size() == 0));
    check("mem_read",  32'(mem_read),  32'(miss));
    check("mem_write", 32'(mem_write), 32'(drain));
    if (miss) begin
      check("load_mem_addr", 32'(mem_addr), 32'(addr));
    end else if (drain) begin
      check("drain_addr",  32'(mem_addr),  32'(pend_q[0].addr));
      check("drain_wdata", 32'(mem_wdata), 32'(pend_q[0].data));
    end else begin
      check("idle_mem_addr",  32'(mem_addr),  32'd0);
      check("idle_mem_wdata", 32'(mem_wdata), 32'd0);
    end
    if (drain) void'(pend_q.pop_front());

    if (acc) begin
      if (we) begin
        if (in_r) begin
          pend_q.push_back('{addr: addr[4:0], data: wdata});
          arch_mem[addr[4:0]] = wdata;
        end else begin
          exp_q.push_back('{due: cyc + 1, is_load: 1'b0, rdata: 8'h00, flt: 1'b1});
        end
      end else begin
        exp_q.push_back('{due: cyc + 1, is_load: 1'b1,
                          rdata: in_r ? arch_mem[addr[4:0]] : 8'h00, flt: !in_r});
      end
    end
  endtask

  // Reset lands just after the negedge sample so an in-flight response is observed first.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    pend_q.delete();
    exp_q.delete();
    foreach (arch_mem[i]) arch_mem[i] = phys_mem[i];
    check_reset_outputs();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: pops whenever the DUT presents a response or one falls due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (resp_valid || fault || (exp_q.size() > 0 && exp_q[0].due <= cyc))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {30'd0, resp_valid, fault}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_cycle", 32'(cyc),        32'(e.due));
          check("resp_valid", 32'(resp_valid), 32'(e.is_load));
          check("fault",      32'(fault),      32'(e.flt));
          if (e.is_load) check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
        end
      end
    end
  end

  initial begin
    logic [7:0] a;
    foreach (phys_mem[i]) phys_mem[i] = 8'($urandom);
    phys_mem[10] = 8'hC3;
    foreach (arch_mem[i]) arch_mem[i] = phys_mem[i];
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    step(1, 1, 8'h03, 8'h5A);
    step(0, 0, 8'h00, 8'h00);
    step(0, 0, 8'h00, 8'h00);

    step(1, 1, 8'h07, 8'h11);
    step(1, 1, 8'h07, 8'h22);
    step(1, 0, 8'h07, 8'h00);
    step(0, 0, 8'h00, 8'h00);

    step(1, 0, 8'h0A, 8'h00);
    step(0, 0, 8'h00, 8'h00);

    step(1, 1, 8'h10, 8'h33);
    step(1, 0, 8'h0B, 8'h00);
    step(1, 1, 8'h11, 8'h44);
    step(1, 0, 8'h0C, 8'h00);
    step(1, 1, 8'h12, 8'h55);
    step(1, 0, 8'h0D, 8'h00);
    step(0, 0, 8'h00, 8'h00);
    step(1, 1, 8'h13, 8'h56);

    step(1, 0, 8'h25, 8'h00);
    step(1, 1, 8'h80, 8'hEE);
    step(0, 0, 8'h00, 8'h00);
    step(0, 0, 8'h00, 8'h00);

    step(1, 1, 8'h14, 8'h66);
    step(1, 1, 8'h15, 8'h77);
    pulse_reset();
    step(0, 0, 8'h00, 8'h00);
    step(1, 0, 8'h15, 8'h00);
    step(0, 0, 8'h00, 8'h00);

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 9) == 0)      a = 8'($urandom_range(32, 255));
      else if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(0, 7));
      else                                a = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, a, 8'($urandom));
    end

    repeat (4) step(0, 0, 8'h00, 8'h00);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
